// File: rtl/mouse_pkg.sv
// Shared types and PS/2 mouse protocol constants for the mouse configuration sequencer.
package mouse_pkg;

    typedef enum logic [2:0] {
        PH_SEND,
        PH_WAIT_TX,
        PH_WAIT_RSP,
        PH_STREAM,
        PH_FAIL
    } phase_t;

    typedef enum logic [2:0] {
        STEP_RST,
        STEP_RATE_CMD,
        STEP_RATE_ARG,
        STEP_RES_CMD,
        STEP_RES_ARG,
        STEP_EN
    } step_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_SET_RES  = 8'hE8;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    // The reset step is answered by ACK, BAT-OK and the device ID; every other step by ACK.
    function automatic logic [7:0] expected_rsp(input step_t step, input logic [1:0] idx);
        logic [7:0] rsp;
        rsp = RSP_ACK;
        if (step == STEP_RST) begin
            case (idx)
                2'd0:    rsp = RSP_ACK;
                2'd1:    rsp = RSP_BAT_OK;
                default: rsp = RSP_ID;
            endcase
        end
        return rsp;
    endfunction

    function automatic logic [1:0] last_rsp_idx(input step_t step);
        return (step == STEP_RST) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Response wait timer: reloads on clear, counts down while enabled, and flags expiry
// once TIMEOUT_CYCLES-1 enabled cycles have elapsed since the last clear.
module ps2_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned  W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= LOAD;
        end else if (clear) begin
            r_count <= LOAD;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired = enable && (r_count == '0);

endmodule

// File: rtl/mouse_init_ctrl.sv
// PS/2 mouse configuration sequencer: reset, set rate, set resolution, enable streaming,
// with per-step resend, full-sequence retries and a sticky FAIL state; then forwards stream bytes.
module mouse_init_ctrl
    import mouse_pkg::*;
#(
    parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
    parameter logic [7:0]  RESOLUTION     = 8'h02,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reinit,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic       ready,
    output logic       error,
    output logic [1:0] retries
);

    localparam logic [1:0] MAX_RETRIES_L = 2'(MAX_RETRIES);

    phase_t     r_phase, w_phase_next;
    step_t      r_step, w_step_next;
    logic [1:0] r_rsp_idx, w_rsp_idx_next;
    logic       r_resent, w_resent_next;
    logic [1:0] r_retries, w_retries_next;
    logic [7:0] r_cmd, w_cmd_next;
    logic       r_send, w_send_next;
    logic [7:0] r_data_out, w_data_out_next;
    logic       r_data_out_en, w_data_out_en_next;

    logic       w_timer_clear;
    logic       w_timer_enable;
    logic       w_timer_expired;
    logic       w_fail;
    logic [7:0] w_step_byte;

    always_comb begin
        case (r_step)
            STEP_RST:      w_step_byte = CMD_RESET;
            STEP_RATE_CMD: w_step_byte = CMD_SET_RATE;
            STEP_RATE_ARG: w_step_byte = SAMPLE_RATE;
            STEP_RES_CMD:  w_step_byte = CMD_SET_RES;
            STEP_RES_ARG:  w_step_byte = RESOLUTION;
            default:       w_step_byte = CMD_ENABLE;
        endcase
    end

    assign w_timer_enable = (r_phase == PH_WAIT_TX) || (r_phase == PH_WAIT_RSP);

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_timer_clear),
        .enable (w_timer_enable),
        .expired(w_timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase       <= PH_SEND;
            r_step        <= STEP_RST;
            r_rsp_idx     <= '0;
            r_resent      <= 1'b0;
            r_retries     <= '0;
            r_cmd         <= '0;
            r_send        <= 1'b0;
            r_data_out    <= '0;
            r_data_out_en <= 1'b0;
        end else begin
            r_phase       <= w_phase_next;
            r_step        <= w_step_next;
            r_rsp_idx     <= w_rsp_idx_next;
            r_resent      <= w_resent_next;
            r_retries     <= w_retries_next;
            r_cmd         <= w_cmd_next;
            r_send        <= w_send_next;
            r_data_out    <= w_data_out_next;
            r_data_out_en <= w_data_out_en_next;
        end
    end

    always_comb begin
        w_phase_next       = r_phase;
        w_step_next        = r_step;
        w_rsp_idx_next     = r_rsp_idx;
        w_resent_next      = r_resent;
        w_retries_next     = r_retries;
        w_cmd_next         = r_cmd;
        w_send_next        = 1'b0;
        w_data_out_next    = r_data_out;
        w_data_out_en_next = 1'b0;
        w_timer_clear      = 1'b0;
        w_fail             = 1'b0;

        case (r_phase)
            PH_SEND: begin
                w_send_next   = 1'b1;
                w_cmd_next    = w_step_byte;
                w_phase_next  = PH_WAIT_TX;
                w_timer_clear = 1'b1;
            end
            PH_WAIT_TX: begin
                // Received bytes are ignored here: the mouse cannot answer a byte still in flight.
                if (command_was_sent) begin
                    w_phase_next  = PH_WAIT_RSP;
                    w_timer_clear = 1'b1;
                end else if (error_communication_timed_out || w_timer_expired) begin
                    w_fail = 1'b1;
                end
            end
            PH_WAIT_RSP: begin
                if (received_data_en) begin
                    if (received_data == expected_rsp(r_step, r_rsp_idx)) begin
                        if (r_rsp_idx != last_rsp_idx(r_step)) begin
                            w_rsp_idx_next = r_rsp_idx + 2'd1;
                            w_timer_clear  = 1'b1;
                        end else if (r_step == STEP_EN) begin
                            w_phase_next = PH_STREAM;
                        end else begin
                            w_step_next    = step_t'(r_step + 3'd1);
                            w_phase_next   = PH_SEND;
                            w_rsp_idx_next = '0;
                            w_resent_next  = 1'b0;
                        end
                    end else if ((received_data == RSP_RESEND) && !r_resent) begin
                        w_resent_next  = 1'b1;
                        w_rsp_idx_next = '0;
                        w_phase_next   = PH_SEND;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (error_communication_timed_out || w_timer_expired) begin
                    w_fail = 1'b1;
                end
            end
            PH_STREAM: begin
                if (received_data_en) begin
                    w_data_out_next    = received_data;
                    w_data_out_en_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_fail) begin
            if (r_retries < MAX_RETRIES_L) begin
                w_retries_next = r_retries + 2'd1;
                w_step_next    = STEP_RST;
                w_phase_next   = PH_SEND;
                w_rsp_idx_next = '0;
                w_resent_next  = 1'b0;
            end else begin
                w_phase_next = PH_FAIL;
            end
        end

        // reinit overrides any same-cycle byte, send completion or failure.
        if (reinit) begin
            w_phase_next       = PH_SEND;
            w_step_next        = STEP_RST;
            w_rsp_idx_next     = '0;
            w_resent_next      = 1'b0;
            w_retries_next     = '0;
            w_send_next        = 1'b0;
            w_data_out_en_next = 1'b0;
        end
    end

    assign the_command  = r_cmd;
    assign send_command = r_send;
    assign data_out     = r_data_out;
    assign data_out_en  = r_data_out_en;
    assign ready        = (r_phase == PH_STREAM);
    assign error        = (r_phase == PH_FAIL);
    assign retries      = r_retries;

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Scoreboard bench for mouse_init_ctrl: a scripted mouse/controller model drives random-timed
// responses, expected commands and stream bytes are queued, and a monitor checks DUT output.
module tb_mouse_init_ctrl;

    localparam int TMO = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       reinit = 1'b0;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic [7:0] data_out;
    logic       data_out_en;
    logic       ready;
    logic       error;
    logic [1:0] retries;

    mouse_init_ctrl #(
        .SAMPLE_RATE(8'd100),
        .RESOLUTION(8'h02),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .reinit(reinit),
        .the_command(the_command),
        .send_command(send_command),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .received_data(received_data),
        .received_data_en(received_data_en),
        .data_out(data_out),
        .data_out_en(data_out_en),
        .ready(ready),
        .error(error),
        .retries(retries)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int t_send = 0;
    int t_ack = 0;

    typedef struct {logic [7:0] cmd; logic [1:0] retr;} cmd_exp_t;
    typedef struct {logic [7:0] b; int due;} data_exp_t;
    cmd_exp_t  exp_cmd_q[$];
    data_exp_t exp_data_q[$];
    cmd_exp_t  mon_c;
    data_exp_t mon_d;

    // Reference command sequence and the replies a healthy mouse gives to each step.
    logic [7:0] base_cmd [6] = '{8'hFF, 8'hF3, 8'd100, 8'hE8, 8'h02, 8'hF4};
    logic [7:0] rst_rsp  [3] = '{8'hFA, 8'hAA, 8'h00};
    logic [7:0] spec_stream [3] = '{8'h08, 8'h05, 8'hFB};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_the_command"}, 32'(the_command), 0);
        check({tag, "_send_command"}, 32'(send_command), 0);
        check({tag, "_data_out"}, 32'(data_out), 0);
        check({tag, "_data_out_en"}, 32'(data_out_en), 0);
        check({tag, "_ready"}, 32'(ready), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_retries"}, 32'(retries), 0);
    endtask

    task automatic push_cmds(input int from, input int to, input logic [1:0] r);
        for (int s = from; s <= to; s++) exp_cmd_q.push_back('{base_cmd[s], r});
    endtask

    // Monitor: every DUT transaction pops the scoreboard and is compared there.
    always @(negedge clock) begin
        if (send_command) begin
            $display("[%0d] send the_command=%02h retries=%0d", cyc, the_command, retries);
            if (exp_cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_send: got the_command=%02h, required no send", the_command);
            end else begin
                mon_c = exp_cmd_q.pop_front();
                check("sent_byte", 32'(the_command), 32'(mon_c.cmd));
                check("retries_at_send", 32'(retries), 32'(mon_c.retr));
            end
        end
        if (data_out_en) begin
            $display("[%0d] stream data_out=%02h", cyc, data_out);
            if (exp_data_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_data: got data_out=%02h, required no output", data_out);
            end else begin
                mon_d = exp_data_q.pop_front();
                check("data_out", 32'(data_out), 32'(mon_d.b));
                check("data_out_latency", 32'(cyc), 32'(mon_d.due));
                check("data_out_while_ready", 32'(ready), 1);
            end
        end
    end

    task automatic wait_send(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (send_command) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL send_wait: no send_command within %0d cycles, required one", budget);
        end
        t_send = cyc;
    endtask

    // Controller completes the transfer; a stray FA during the transfer must be ignored.
    task automatic ack_tx();
        repeat ($urandom_range(0, 3)) @(negedge clock);
        if ($urandom_range(0, 1) == 1) begin
            received_data = 8'hFA; received_data_en = 1'b1;
            @(negedge clock);
            received_data_en = 1'b0;
        end
        command_was_sent = 1'b1; t_ack = cyc;
        @(negedge clock);
        command_was_sent = 1'b0;
    endtask

    task automatic send_rsp(input logic [7:0] b, input bit last);
        repeat ($urandom_range(0, 4)) @(negedge clock);
        if (last) check("ready_before_last_ack", 32'(ready), 0);
        received_data = b; received_data_en = 1'b1;
        @(negedge clock);
        received_data_en = 1'b0;
        if (last) begin
            check("ready_after_last_ack", 32'(ready), 1);
            check("error_after_last_ack", 32'(error), 0);
        end
    endtask

    task automatic run_sequence(input int fe_step, input int bad_step);
        logic [7:0] r;
        for (int s = 0; s < 6; s++) begin
            wait_send(TMO + 200);
            ack_tx();
            if (s == fe_step) begin
                send_rsp(8'hFE, 1'b0);
                wait_send(TMO + 200);
                ack_tx();
            end
            if (s == bad_step) begin
                do r = 8'($urandom_range(0, 255)); while (r == 8'hFA || r == 8'hFE);
                send_rsp(r, 1'b0);
                return;
            end
            if (s == 0) begin
                for (int k = 0; k < 3; k++) send_rsp(rst_rsp[k], 1'b0);
            end else begin
                send_rsp(8'hFA, s == 5);
            end
        end
    endtask

    task automatic do_reinit(input bit with_byte);
        @(negedge clock);
        reinit = 1'b1;
        if (with_byte) begin
            received_data = 8'($urandom_range(0, 255)); received_data_en = 1'b1;
        end
        @(negedge clock);
        reinit = 1'b0; received_data_en = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe, bad, d;
        logic [7:0] b;

        // Reset values, then nominal bring-up.
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        push_cmds(0, 5, 2'd0);
        reset = 1'b0;
        run_sequence(-1, -1);
        check("nominal_retries", 32'(retries), 0);
        check("nominal_error", 32'(error), 0);

        // Stream forwarding: required bytes first, then random ones.
        for (int i = 0; i < 8; i++) begin
            b = (i < 3) ? spec_stream[i] : 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            exp_data_q.push_back('{b, cyc + 1});
            received_data = b; received_data_en = 1'b1;
            @(negedge clock);
            received_data_en = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("stream_queue_drained", 32'(exp_data_q.size()), 0);

        // Resend at a random step; reinit coincides with a stream byte that must be dropped.
        fe = $urandom_range(0, 5);
        for (int s = 0; s < 6; s++) begin
            exp_cmd_q.push_back('{base_cmd[s], 2'd0});
            if (s == fe) exp_cmd_q.push_back('{base_cmd[s], 2'd0});
        end
        do_reinit(1'b1);
        run_sequence(fe, -1);
        check("resend_retries", 32'(retries), 0);

        // Unexpected response byte at a random step forces one full restart.
        bad = $urandom_range(0, 5);
        push_cmds(0, bad, 2'd0);
        push_cmds(0, 5, 2'd1);
        do_reinit(1'b0);
        run_sequence(-1, bad);
        run_sequence(-1, -1);
        check("badbyte_retries", 32'(retries), 1);

        // Mouse never answers the reset: three restarts, then FAIL.
        for (int k = 0; k < 4; k++) exp_cmd_q.push_back('{8'hFF, 2'(k)});
        do_reinit(1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_send(TMO + 200);
            if (k > 0) begin
                d = t_send - t_ack;
                checks++;
                if (d < TMO || d > TMO + 4) begin
                    errors++;
                    $display("FAIL restart_interval: got %0d cycles, required %0d..%0d", d, TMO, TMO + 4);
                end
            end
            ack_tx();
        end
        for (int i = 0; i < TMO + 200; i++) begin
            if (error) break;
            @(negedge clock);
        end
        check("fail_error", 32'(error), 1);
        check("fail_retries", 32'(retries), 3);
        check("fail_ready", 32'(ready), 0);
        repeat (100) @(negedge clock);

        // Recovery from FAIL.
        exp_cmd_q.push_back('{8'hFF, 2'd0});
        do_reinit(1'b0);
        check("recover_error", 32'(error), 0);
        check("recover_retries", 32'(retries), 0);
        wait_send(2);

        // Asynchronous reset in WAIT_RSP, asserted between clock edges.
        ack_tx();
        send_rsp(8'hFA, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        exp_cmd_q.push_back('{8'hFF, 2'd0});
        @(negedge clock);
        command_was_sent = 1'b1;
        @(negedge clock);
        command_was_sent = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        wait_send(3);
        repeat (5) @(negedge clock);

        check("cmd_queue_drained", 32'(exp_cmd_q.size()), 0);
        check("data_queue_drained", 32'(exp_data_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
